fetch_decode: RTL and testbench
===============================

Name: fetch_decode

Overview:
- Instruction fetch and decode stage of the 8-bit core; sits directly upstream of Sign_Extend.
- Owns the PC and drives a synchronous instruction ROM.
- Latches each 8-bit instruction and splits it into register fields, the 2-bit immediate (wired to Sign_Extend.signImm) and control strobes.
- Hands each decoded instruction to the execute stage over a valid/ready handshake.

Parameters:
- PC_WIDTH, 8, width of PC and ROM address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- run  input  1  level; 1 = fetch instructions, 0 = stop at next instruction boundary.
- rom_en  output  1  ROM read enable.
- rom_addr  output  PC_WIDTH  ROM address.
- rom_data  input  8  ROM read data; valid the cycle after rom_en.
- pc  output  PC_WIDTH  current PC (address of next fetch).
- dec_valid  output  1  decoded instruction available.
- dec_ready  input  1  execute stage accepts instruction.
- pc_load  input  1  redirect PC (jump); sampled only on handshake.
- pc_load_value  input  PC_WIDTH  redirect target.
- opcode  output  2  ir[7:6].
- rs  output  2  ir[5:4].
- rt  output  2  ir[3:2].
- rd  output  2  ir[1:0].
- imm  output  2  ir[1:0]; to Sign_Extend.signImm.
- reg_write, mem_read, mem_write, jump  output  1 each  decoded control.

Behaviour:
- Reset values: state IDLE, pc=RESET_PC, ir=0x00, all field and control outputs 0, dec_valid=0, rom_en=0, rom_addr=pc.
- rom_addr is always equal to pc (combinational).
- States:
  - IDLE: outputs quiet. run=1 -> FETCH.
  - FETCH: rom_en=1 for exactly one cycle -> LATCH.
  - LATCH: ir<=rom_data; pc<=pc+1 (mod 2^PC_WIDTH, 0xFF -> 0x00) -> DECODE.
  - DECODE: fields and control are valid and stable; Sign_Extend samples imm on this cycle's edge; dec_valid=0 -> ISSUE.
  - ISSUE: dec_valid=1. Stay while dec_ready=0, holding all outputs. On dec_ready=1 (handshake):
    - if pc_load=1, pc<=pc_load_value;
    - next state FETCH if run=1, else IDLE.
- Fields and control update only at the LATCH edge and hold until the next LATCH. The sign-extended immediate is therefore valid for the whole ISSUE period.
- Minimum 4 cycles per instruction; one extra cycle per cycle of ISSUE stall.
- Decode (op = ir[7:6]):
  - 00 add: reg_write=1.
  - 01 load: reg_write=1, mem_read=1.
  - 10 store: mem_write=1.
  - 11 jump: jump=1.
  - All other control outputs 0.
- pc_load outside the handshake cycle is ignored.
- pc_load with jump=0 is still honoured; the execute stage owns that decision.
- run=0 mid-instruction: the current instruction completes through the ISSUE handshake, then the block goes IDLE. run is not sampled in FETCH, LATCH or DECODE.
- rom_data is sampled only in LATCH.
- reset asserted in any state: immediate return to reset values; the in-flight instruction is discarded. After reset deasserts, the first fetch is from RESET_PC.

Test Plan:
- Reset then run=1, ROM[0]=0x1B, dec_ready=1 -> rom_en pulses at cycle 1. At ISSUE: opcode=00, rs=01, rt=10, rd=11, imm=11, reg_write=1, pc=1, Sign_Extend output=0xFF.
- ROM[0..2]=0x42,0x86,0xC2 (ROM[1]=0x86), dec_ready=1 -> dec_valid asserts every 4th cycle. Decoded in order: load (mem_read=1, imm=10), store (mem_write=1, imm=10), jump (jump=1, imm=10). pc=3 after the third instruction.
- dec_ready held 0 for 5 cycles in ISSUE -> dec_valid and all fields stable, pc unchanged, rom_en=0; handshake on the 6th cycle, fetch resumes next cycle.
- Jump at pc=4 with pc_load=1, pc_load_value=0x10 on handshake -> next rom_addr=0x10. pc_load=1 during stall cycles has no effect.
- pc=0xFF, fetch -> pc wraps to 0x00 at LATCH.
- reset pulsed during LATCH -> outputs at reset values in the same cycle. Then run=0, handshake during ISSUE -> state IDLE, no further rom_en.

Source files
------------

// File: rtl/fetch_decode.sv
// Fetch/decode stage of the 8-bit core: owns the PC, reads one byte per instruction from a
// synchronous ROM, and presents decoded fields and strobes to execute over valid/ready.
module fetch_decode #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                rom_en,
    output logic [PC_WIDTH-1:0] rom_addr,
    input  logic [7:0]          rom_data,
    output logic [PC_WIDTH-1:0] pc,
    output logic                dec_valid,
    input  logic                dec_ready,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:0] pc_load_value,
    output logic [1:0]          opcode,
    output logic [1:0]          rs,
    output logic [1:0]          rt,
    output logic [1:0]          rd,
    output logic [1:0]          imm,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                jump
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_ISSUE
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [7:0]          r_ir;
    logic                r_rom_en;
    logic                r_dec_valid;
    logic                r_reg_write;
    logic                r_mem_read;
    logic                r_mem_write;
    logic                r_jump;

    // Control strobes decoded straight from the ROM byte so they land together with ir.
    logic w_reg_write;
    logic w_mem_read;
    logic w_mem_write;
    logic w_jump;

    always_comb begin
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_jump      = 1'b0;
        case (rom_data[7:6])
            2'b00: w_reg_write = 1'b1;
            2'b01: begin
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
            end
            2'b10: w_mem_write = 1'b1;
            default: w_jump = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_ir        <= 8'h00;
            r_rom_en    <= 1'b0;
            r_dec_valid <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_jump      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state  <= S_FETCH;
                        r_rom_en <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_rom_en <= 1'b0;
                    r_state  <= S_LATCH;
                end
                S_LATCH: begin
                    r_ir        <= rom_data;
                    r_reg_write <= w_reg_write;
                    r_mem_read  <= w_mem_read;
                    r_mem_write <= w_mem_write;
                    r_jump      <= w_jump;
                    r_pc        <= r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                    r_state     <= S_DECODE;
                end
                S_DECODE: begin
                    r_dec_valid <= 1'b1;
                    r_state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Redirect and run are only honoured on the accepting edge.
                    if (dec_ready) begin
                        r_dec_valid <= 1'b0;
                        if (pc_load) begin
                            r_pc <= pc_load_value;
                        end
                        if (run) begin
                            r_state  <= S_FETCH;
                            r_rom_en <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rom_en    <= 1'b0;
                    r_dec_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign rom_addr  = r_pc;
    assign rom_en    = r_rom_en;
    assign dec_valid = r_dec_valid;
    assign opcode    = r_ir[7:6];
    assign rs        = r_ir[5:4];
    assign rt        = r_ir[3:2];
    assign rd        = r_ir[1:0];
    assign imm       = r_ir[1:0];
    assign reg_write = r_reg_write;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign jump      = r_jump;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode with a behavioural synchronous ROM; every expected
// value below is hand-derived from the instruction encoding and the 4-cycle schedule.
module tb_fetch_decode;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       rom_en;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] pc;
    logic       dec_valid;
    logic       dec_ready;
    logic       pc_load;
    logic [7:0] pc_load_value;
    logic [1:0] opcode, rs, rt, rd, imm;
    logic       reg_write, mem_read, mem_write, jump;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] rom [256];

    fetch_decode #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .run(run),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .pc(pc), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .pc_load(pc_load), .pc_load_value(pc_load_value),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .jump(jump)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Advances until dec_valid rises (bounded); returns the number of cycles taken.
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!dec_valid && n < 20);
        chk(tag, {31'd0, dec_valid}, 32'd1);
    endtask

    int n;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom_data = 8'h00;
        reset = 1'b1; run = 1'b0; dec_ready = 1'b0; pc_load = 1'b0; pc_load_value = 8'h00;
        rom[0] = 8'h1B;
        tick(); tick();

        // Reset state
        chk("rst_pc", pc, 8'h00);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_ctrl", {reg_write, mem_read, mem_write, jump}, 4'b0000);
        chk("rst_fields", {opcode, rs, rt, rd}, 8'h00);
        chk("rst_rom_addr", rom_addr, 8'h00);

        // Single add 0x1B
        @(negedge clk); reset = 1'b0; run = 1'b1; dec_ready = 1'b1;
        tick();
        chk("t1_rom_en_c1", rom_en, 1);
        tick();
        chk("t1_rom_en_c2", rom_en, 0);
        tick();
        chk("t1_decode_valid", dec_valid, 0);
        chk("t1_decode_pc", pc, 8'h01);
        tick();
        chk("t1_issue_valid", dec_valid, 1);
        chk("t1_fields", {opcode, rs, rt, rd}, {2'b00, 2'b01, 2'b10, 2'b11});
        chk("t1_imm", imm, 2'b11);
        chk("t1_ctrl", {reg_write, mem_read, mem_write, jump}, 4'b1000);
        chk("t1_pc", pc, 8'h01);

        // Back-to-back load, store, jump
        rom[0] = 8'h42; rom[1] = 8'h86; rom[2] = 8'hC2; rom[3] = 8'hC0;
        do_reset();
        wait_valid("t2_v0", n);
        chk("t2_lat0", n, 4);
        chk("t2_ctrl0", {reg_write, mem_read, mem_write, jump}, 4'b1100);
        chk("t2_imm0", imm, 2'b10);
        wait_valid("t2_v1", n);
        chk("t2_lat1", n, 4);
        chk("t2_ctrl1", {reg_write, mem_read, mem_write, jump}, 4'b0010);
        chk("t2_imm1", imm, 2'b10);
        wait_valid("t2_v2", n);
        chk("t2_lat2", n, 4);
        chk("t2_ctrl2", {reg_write, mem_read, mem_write, jump}, 4'b0001);
        chk("t2_imm2", imm, 2'b10);
        chk("t2_pc", pc, 8'h03);

        // Stall five ISSUE cycles; pc_load during stall is ignored
        dec_ready = 1'b0; pc_load = 1'b1; pc_load_value = 8'h55;
        for (int c = 0; c < 5; c++) begin
            chk("t3_stall_valid", dec_valid, 1);
            chk("t3_stall_fields", {opcode, rs, rt, rd}, 8'hC2);
            chk("t3_stall_pc", pc, 8'h03);
            chk("t3_stall_rom_en", rom_en, 0);
            if (c < 4) tick();
        end
        dec_ready = 1'b1; pc_load = 1'b0;
        tick();
        chk("t3_resume_rom_en", rom_en, 1);
        chk("t3_resume_addr", rom_addr, 8'h03);
        chk("t3_resume_valid", dec_valid, 0);

        // Jump at pc=4 with redirect to 0x10
        rom[8'h10] = 8'h00;
        wait_valid("t4_v", n);
        chk("t4_jump", jump, 1);
        chk("t4_pc", pc, 8'h04);
        pc_load = 1'b1; pc_load_value = 8'h10;
        tick();
        chk("t4_redirect_addr", rom_addr, 8'h10);
        chk("t4_redirect_en", rom_en, 1);
        pc_load = 1'b0;

        // Redirect to 0xFF then wrap on LATCH
        rom[8'hFF] = 8'h5A;
        wait_valid("t5_v", n);
        chk("t5_pc", pc, 8'h11);
        pc_load = 1'b1; pc_load_value = 8'hFF;
        tick();
        chk("t5_pc_ff", pc, 8'hFF);
        pc_load = 1'b0;
        tick();
        chk("t5_latch_pc", pc, 8'hFF);
        tick();
        chk("t5_wrap_pc", pc, 8'h00);
        chk("t5_fields", {opcode, rs, rt, rd}, {2'b01, 2'b01, 2'b10, 2'b10});
        chk("t5_ctrl", {reg_write, mem_read, mem_write, jump}, 4'b1100);

        // Asynchronous reset during LATCH
        tick();             // ISSUE
        tick();             // FETCH at pc=0
        tick();             // LATCH
        chk("t6_pre_pc", pc, 8'h00);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_pc", pc, 8'h00);
        chk("t6_async_valid", dec_valid, 0);
        chk("t6_async_ctrl", {reg_write, mem_read, mem_write, jump}, 4'b0000);
        chk("t6_async_fields", {opcode, rs, rt, rd}, 8'h00);
        chk("t6_async_rom_en", rom_en, 0);
        @(negedge clk); reset = 1'b0;
        tick();
        chk("t6_fetch_en", rom_en, 1);
        chk("t6_fetch_addr", rom_addr, 8'h00);
        run = 1'b0;
        wait_valid("t6_v", n);
        chk("t6_lat", n, 3);
        chk("t6_ctrl", {reg_write, mem_read, mem_write, jump}, 4'b1100);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t6_idle_rom_en", rom_en, 0);
            chk("t6_idle_valid", dec_valid, 0);
            chk("t6_idle_pc", pc, 8'h01);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
